// File: rtl/sc_countdown_pkg.sv
// Shared types and defaults for the countdown timer.
// State encoding is fixed so other game blocks can decode it.
package sc_countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_PAUSE   = 2'b10,
      ST_EXPIRED = 2'b11
   } cd_state_t;

   localparam int DEFAULT_TICKDIVISOR = 4;
   localparam int DEFAULT_DATAWIDTH   = 8;

endpackage

// File: rtl/sc_tickprescaler.sv
// Modulo-N prescaler; tick flags the terminal phase so the
// consumer decides whether that phase is an advancing edge.
module sc_tickprescaler
   import sc_countdown_pkg::*;
#(
   parameter int TICKDIVISOR = DEFAULT_TICKDIVISOR,
   localparam int W = (TICKDIVISOR > 1) ? $clog2(TICKDIVISOR) : 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [W-1:0] LAST = W'(TICKDIVISOR - 1);

   logic [W-1:0] value;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         value <= '0;
      end else if (enable) begin
         value <= (value == LAST) ? '0 : value + 1'b1;
      end
   end

   assign tick = (value == LAST);

endmodule

// File: rtl/sc_countdowntimer.sv
// Loadable, pausable down-counter with zero level and expire pulse.
// Feeds the game-control FSM alongside the score path.
module sc_countdowntimer
   import sc_countdown_pkg::*;
#(
   parameter int COUNTDOWN_DATAWIDTH   = DEFAULT_DATAWIDTH,
   parameter int COUNTDOWN_TICKDIVISOR = DEFAULT_TICKDIVISOR
) (
   input  logic                           SC_COUNTDOWN_CLOCK_50,
   input  logic                           SC_COUNTDOWN_RESET_InHigh,
   input  logic                           SC_COUNTDOWN_load_InLow,
   input  logic [COUNTDOWN_DATAWIDTH-1:0] SC_COUNTDOWN_loadvalue_InBUS,
   input  logic                           SC_COUNTDOWN_start_InLow,
   input  logic                           SC_COUNTDOWN_pause_InLow,
   output logic [COUNTDOWN_DATAWIDTH-1:0] SC_COUNTDOWN_data_OutBUS,
   output logic                           SC_COUNTDOWN_zero_Out,
   output logic                           SC_COUNTDOWN_expired_Out,
   output logic                           SC_COUNTDOWN_running_Out
);

   localparam int DW = COUNTDOWN_DATAWIDTH;

   cd_state_t       state, state_nx;
   logic [DW-1:0]   count, count_nx;
   logic            expired, expired_nx;
   logic            running;
   logic            presc_clear, presc_en, tick;

   sc_tickprescaler #(
      .TICKDIVISOR (COUNTDOWN_TICKDIVISOR)
   ) u_presc (
      .clock  (SC_COUNTDOWN_CLOCK_50),
      .reset  (SC_COUNTDOWN_RESET_InHigh),
      .clear  (presc_clear),
      .enable (presc_en),
      .tick   (tick)
   );

   always_ff @(posedge SC_COUNTDOWN_CLOCK_50) begin
      if (SC_COUNTDOWN_RESET_InHigh) begin
         state   <= ST_IDLE;
         count   <= '0;
         expired <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         expired <= expired_nx;
         running <= (state_nx == ST_RUN);
      end
   end

   always_comb begin
      state_nx    = state;
      count_nx    = count;
      expired_nx  = 1'b0;
      presc_clear = 1'b0;
      presc_en    = 1'b0;
      if (!SC_COUNTDOWN_load_InLow) begin
         count_nx    = SC_COUNTDOWN_loadvalue_InBUS;
         state_nx    = ST_IDLE;
         presc_clear = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (!SC_COUNTDOWN_start_InLow) begin
                  if (count != '0) begin
                     state_nx    = ST_RUN;
                     presc_clear = 1'b1;
                  end else begin
                     state_nx   = ST_EXPIRED;
                     expired_nx = 1'b1;
                  end
               end
            end
            // Releasing pause advances on that same edge: no phase loss
            ST_RUN, ST_PAUSE: begin
               if (!SC_COUNTDOWN_pause_InLow) begin
                  state_nx = ST_PAUSE;
               end else begin
                  state_nx = ST_RUN;
                  presc_en = 1'b1;
                  if (tick && count != '0) begin
                     count_nx = count - 1'b1;
                     if (count == DW'(1)) begin
                        state_nx   = ST_EXPIRED;
                        expired_nx = 1'b1;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign SC_COUNTDOWN_data_OutBUS = count;
   assign SC_COUNTDOWN_zero_Out    = (count == '0);
   assign SC_COUNTDOWN_expired_Out = expired;
   assign SC_COUNTDOWN_running_Out = running;

endmodule

// File: tb/tb_sc_countdowntimer.sv
// Bench for sc_countdowntimer: directed scenarios plus random
// traffic, all compared against an elapsed-time reference model.
module tb_sc_countdowntimer;

   localparam int DW = 8;
   localparam int TD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_n = 1'b1;
   logic [DW-1:0] lv = '0;
   logic          start_n = 1'b1;
   logic          pause_n = 1'b1;
   logic [DW-1:0] data;
   logic          zero, expired, running;

   int total = 0;
   int bad   = 0;

   // Model: count = loaded - (advancing edges since start) / TD
   int m_load = 0;
   int m_act  = 0;
   int m_mode = 0;
   int m_pulse = 0;

   always #5 clk = ~clk;

   sc_countdowntimer #(
      .COUNTDOWN_DATAWIDTH   (DW),
      .COUNTDOWN_TICKDIVISOR (TD)
   ) dut (
      .SC_COUNTDOWN_CLOCK_50        (clk),
      .SC_COUNTDOWN_RESET_InHigh    (rst),
      .SC_COUNTDOWN_load_InLow      (load_n),
      .SC_COUNTDOWN_loadvalue_InBUS (lv),
      .SC_COUNTDOWN_start_InLow     (start_n),
      .SC_COUNTDOWN_pause_InLow     (pause_n),
      .SC_COUNTDOWN_data_OutBUS     (data),
      .SC_COUNTDOWN_zero_Out        (zero),
      .SC_COUNTDOWN_expired_Out     (expired),
      .SC_COUNTDOWN_running_Out     (running)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_count();
      int c;
      c = m_load - m_act / TD;
      return (c < 0) ? 0 : c;
   endfunction

   task automatic m_edge(input bit r, input bit ld, input int v,
                         input bit st, input bit pa);
      m_pulse = 0;
      if (r) begin
         m_load = 0; m_act = 0; m_mode = 0;
      end else if (!ld) begin
         m_load = v; m_act = 0; m_mode = 0;
      end else if (m_mode == 0) begin
         if (!st) begin
            if (m_count() == 0) begin
               m_mode = 3; m_pulse = 1;
            end else begin
               m_mode = 1;
            end
         end
      end else if (m_mode == 1 || m_mode == 2) begin
         if (!pa) begin
            m_mode = 2;
         end else begin
            m_mode = 1;
            m_act++;
            if (m_count() == 0) begin
               m_mode = 3; m_pulse = 1;
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit ld, input logic [DW-1:0] v,
                       input bit st, input bit pa);
      @(negedge clk);
      rst = r; load_n = ld; lv = v; start_n = st; pause_n = pa;
      @(posedge clk);
      m_edge(r, ld, int'(v), st, pa);
      #1;
      check("data", 32'(data), 32'(m_count()));
      check("zero", 32'(zero), 32'(m_count() == 0));
      check("expired", 32'(expired), 32'(m_pulse));
      check("running", 32'(running), 32'(m_mode == 1));
   endtask

   task automatic idle(input int n, input bit pa);
      for (int i = 0; i < n; i++) step(0, 1, 8'd0, 1, pa);
   endtask

   initial begin
      step(1, 1, 8'd0, 1, 1);
      step(1, 1, 8'd0, 1, 1);
      check("rst_data", 32'(data), 32'd0);
      check("rst_zero", 32'(zero), 32'd1);

      // Plain countdown of 3
      step(0, 0, 8'd3, 1, 1);
      step(0, 1, 8'd0, 0, 1);
      for (int i = 1; i <= 13; i++) begin
         step(0, 1, 8'd0, 1, 1);
         if (i == 3)  check("cd_k3", 32'(data), 32'd3);
         if (i == 4)  check("cd_k4", 32'(data), 32'd2);
         if (i == 8)  check("cd_k8", 32'(data), 32'd1);
         if (i == 11) check("cd_exp_early", 32'(expired), 32'd0);
         if (i == 12) check("cd_exp", 32'(expired), 32'd1);
         if (i == 12) check("cd_k12", 32'(data), 32'd0);
         if (i == 13) check("cd_exp_clr", 32'(expired), 32'd0);
         if (i == 13) check("cd_run_off", 32'(running), 32'd0);
      end

      // Pause for 6 edges after k+2
      step(0, 0, 8'd3, 1, 1);
      step(0, 1, 8'd0, 0, 1);
      for (int i = 1; i <= 19; i++) begin
         step(0, 1, 8'd0, 1, (i >= 3 && i <= 8) ? 1'b0 : 1'b1);
         if (i == 9)  check("ps_k9", 32'(data), 32'd3);
         if (i == 10) check("ps_k10", 32'(data), 32'd2);
         if (i == 17) check("ps_k17", 32'(expired), 32'd0);
         if (i == 18) check("ps_k18", 32'(expired), 32'd1);
      end

      // Load 0 then start
      step(0, 0, 8'd0, 1, 1);
      step(0, 1, 8'd0, 0, 1);
      check("z_exp", 32'(expired), 32'd1);
      step(0, 1, 8'd0, 0, 1);
      check("z_again", 32'(expired), 32'd0);

      // Load and start together
      step(0, 0, 8'd7, 0, 1);
      check("ls_data", 32'(data), 32'd7);
      check("ls_run", 32'(running), 32'd0);
      idle(1, 1);
      step(0, 1, 8'd0, 0, 1);
      check("ls_start", 32'(running), 32'd1);

      // Load wins on a tick edge
      step(0, 0, 8'd9, 1, 1);
      step(0, 1, 8'd0, 0, 1);
      idle(3, 1);
      step(0, 0, 8'd200, 1, 1);
      check("ld_tick", 32'(data), 32'd200);
      step(0, 1, 8'd0, 0, 1);
      idle(4, 1);
      check("ld_200", 32'(data), 32'd199);

      // Full-scale load
      step(0, 0, 8'd255, 1, 1);
      step(0, 1, 8'd0, 0, 1);
      idle(8, 1);
      check("ff_data", 32'(data), 32'd253);

      // Reset mid-run
      step(0, 0, 8'd5, 1, 1);
      step(0, 1, 8'd0, 0, 1);
      idle(2, 1);
      step(1, 1, 8'd0, 1, 1);
      check("mr_data", 32'(data), 32'd0);
      check("mr_run", 32'(running), 32'd0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         automatic int sel = $urandom_range(0, 9);
         automatic logic [DW-1:0] v;
         v = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255
                                : 8'($urandom_range(1, 6));
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 39) != 0, v,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 5) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
